// File: rtl/ast_width_reducer_pkg.sv
// Shared widths, FSM state type and beat-sizing helpers for the Avalon-ST width reducer.
// Optional build macro AST_WIDTH_REDUCER_REG_READY_EN is consumed by rtl/ast_width_reducer.sv.
package ast_width_reducer_pkg;
  localparam int DATA_IN_W   = 64;
  localparam int DATA_OUT_W  = 16;
  localparam int CHANNEL_W   = 10;
  localparam int N           = DATA_IN_W / DATA_OUT_W;
  localparam int WB          = DATA_OUT_W / 8;
  localparam int IB          = DATA_IN_W / 8;
  localparam int EMPTY_IN_W  = $clog2(IB);
  localparam int EMPTY_OUT_W = (WB > 1) ? $clog2(WB) : 1;
  localparam int IDX_W       = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index of the final narrow word a wide beat produces; empty only matters on eop beats.
  function automatic logic [IDX_W-1:0] words_in_beat(input logic eop,
                                                     input logic [EMPTY_IN_W-1:0] empty);
    int vb;
    vb = IB - int'(empty);
    if (eop) return IDX_W'((vb + WB - 1) / WB - 1);
    else return IDX_W'(N - 1);
  endfunction

  function automatic logic [EMPTY_OUT_W-1:0] eop_word_empty(input logic [EMPTY_IN_W-1:0] empty);
    int vb;
    vb = IB - int'(empty);
    return EMPTY_OUT_W'(((vb + WB - 1) / WB) * WB - vb);
  endfunction
endpackage

// File: rtl/ast_width_reducer_if.sv
// Wide input and narrow output Avalon-ST port sets of the width reducer.
// slave is the reducer's view, master is the environment driving it.
interface ast_width_reducer_if;
  import ast_width_reducer_pkg::*;

  logic [DATA_IN_W-1:0]   ast_data_i;
  logic                   ast_startofpacket_i;
  logic                   ast_endofpacket_i;
  logic                   ast_valid_i;
  logic [EMPTY_IN_W-1:0]  ast_empty_i;
  logic [CHANNEL_W-1:0]   ast_channel_i;
  logic                   ast_ready_o;
  logic [DATA_OUT_W-1:0]  ast_data_o;
  logic                   ast_startofpacket_o;
  logic                   ast_endofpacket_o;
  logic                   ast_valid_o;
  logic [EMPTY_OUT_W-1:0] ast_empty_o;
  logic [CHANNEL_W-1:0]   ast_channel_o;
  logic                   ast_ready_i;

  modport slave (
    input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
           ast_empty_i, ast_channel_i, ast_ready_i,
    output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
           ast_valid_o, ast_empty_o, ast_channel_o
  );

  modport master (
    output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
           ast_empty_i, ast_channel_i, ast_ready_i,
    input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
           ast_valid_o, ast_empty_o, ast_channel_o
  );
endinterface

// File: rtl/ast_width_reducer.sv
// Avalon-ST width down-converter: one held wide beat is replayed as narrow words.
// Define AST_WIDTH_REDUCER_REG_READY_EN for a registered ready (one bubble per beat).
module ast_width_reducer
  import ast_width_reducer_pkg::*;
(
  input logic                clk_i,
  input logic                srst_n_i,
  ast_width_reducer_if.slave ast
);
  state_t                 r_state;
  logic                   r_idle_rdy;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_last_idx;
  logic [DATA_IN_W-1:0]   r_data;
  logic                   r_eop;
  logic [EMPTY_OUT_W-1:0] r_pad;
  logic                   r_valid_o;
  logic                   r_sop_o;
  logic                   r_eop_o;
  logic [DATA_OUT_W-1:0]  r_data_o;
  logic [EMPTY_OUT_W-1:0] r_empty_o;
  logic [CHANNEL_W-1:0]   r_channel_o;

  logic                   w_ready;
  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic                   w_at_last;
  logic                   w_nx_last;
  logic                   w_in_single;
  logic [IDX_W-1:0]       w_idx_inc;
  logic [IDX_W-1:0]       w_in_last_idx;
  logic [EMPTY_OUT_W-1:0] w_in_pad;

  assign w_at_last     = (r_idx == r_last_idx);
  assign w_idx_inc     = r_idx + IDX_W'(1);
  assign w_nx_last     = (w_idx_inc == r_last_idx);
  assign w_in_last_idx = words_in_beat(ast.ast_endofpacket_i, ast.ast_empty_i);
  assign w_in_pad      = eop_word_empty(ast.ast_empty_i);
  assign w_in_single   = ast.ast_endofpacket_i && (w_in_last_idx == {IDX_W{1'b0}});

`ifdef AST_WIDTH_REDUCER_REG_READY_EN
  assign w_ready = r_idle_rdy;
`else
  // The last word leaving frees the buffer in the same cycle, so ready tracks ready_i there.
  assign w_ready = r_idle_rdy || ((r_state == SEND) && w_at_last && ast.ast_ready_i);
`endif

  assign w_in_xfer  = ast.ast_valid_i && w_ready;
  assign w_out_xfer = r_valid_o && ast.ast_ready_i;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_state     <= IDLE;
      r_idle_rdy  <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_last_idx  <= {IDX_W{1'b0}};
      r_data      <= {DATA_IN_W{1'b0}};
      r_eop       <= 1'b0;
      r_pad       <= {EMPTY_OUT_W{1'b0}};
      r_valid_o   <= 1'b0;
      r_sop_o     <= 1'b0;
      r_eop_o     <= 1'b0;
      r_data_o    <= {DATA_OUT_W{1'b0}};
      r_empty_o   <= {EMPTY_OUT_W{1'b0}};
      r_channel_o <= {CHANNEL_W{1'b0}};
    end else if (w_in_xfer) begin
      r_state     <= SEND;
      r_idle_rdy  <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_last_idx  <= w_in_last_idx;
      r_data      <= ast.ast_data_i;
      r_eop       <= ast.ast_endofpacket_i;
      r_pad       <= w_in_pad;
      r_valid_o   <= 1'b1;
      r_sop_o     <= ast.ast_startofpacket_i;
      r_eop_o     <= w_in_single;
      r_data_o    <= ast.ast_data_i[DATA_OUT_W-1:0];
      r_empty_o   <= w_in_single ? w_in_pad : {EMPTY_OUT_W{1'b0}};
      r_channel_o <= ast.ast_channel_i;
    end else begin
      case (r_state)
        IDLE: r_idle_rdy <= 1'b1;
        SEND: begin
          if (w_out_xfer && !w_at_last) begin
            r_idx     <= w_idx_inc;
            r_sop_o   <= 1'b0;
            r_eop_o   <= r_eop && w_nx_last;
            r_data_o  <= r_data[w_idx_inc*DATA_OUT_W +: DATA_OUT_W];
            r_empty_o <= (r_eop && w_nx_last) ? r_pad : {EMPTY_OUT_W{1'b0}};
          end else if (w_out_xfer) begin
            r_state    <= IDLE;
            r_idle_rdy <= 1'b1;
            r_valid_o  <= 1'b0;
            r_sop_o    <= 1'b0;
            r_eop_o    <= 1'b0;
            r_empty_o  <= {EMPTY_OUT_W{1'b0}};
          end else begin
            r_idx <= r_idx;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_idle_rdy <= 1'b1;
          r_valid_o  <= 1'b0;
        end
      endcase
    end
  end

  assign ast.ast_ready_o         = w_ready;
  assign ast.ast_valid_o         = r_valid_o;
  assign ast.ast_startofpacket_o = r_sop_o;
  assign ast.ast_endofpacket_o   = r_eop_o;
  assign ast.ast_data_o          = r_data_o;
  assign ast.ast_empty_o         = r_empty_o;
  assign ast.ast_channel_o       = r_channel_o;
endmodule

// File: tb/tb_ast_width_reducer.sv
// Self-checking bench for ast_width_reducer: byte-count reference model, directed and random scenarios.
module tb_ast_width_reducer;
  import ast_width_reducer_pkg::*;

`ifdef AST_WIDTH_REDUCER_REG_READY_EN
  localparam bit REG_RDY = 1'b1;
`else
  localparam bit REG_RDY = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_IN_W-1:0]  data;
    logic                  sop;
    logic                  eop;
    logic [EMPTY_IN_W-1:0] empty;
    logic [CHANNEL_W-1:0]  ch;
  } beat_t;

  typedef struct packed {
    logic [DATA_OUT_W-1:0]  d;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_OUT_W-1:0] emp;
    logic [CHANNEL_W-1:0]   ch;
  } word_t;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  ast_width_reducer_if vif();
  ast_width_reducer dut (.clk_i(clk), .srst_n_i(srst_n), .ast(vif));

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit src_done;
  beat_t beat_q[$];
  word_t exp_q[$];
  word_t obs_q[$];
  int obs_cyc[$];
  int acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every word transfer and every beat acceptance with its cycle number.
  always @(negedge clk) begin
    if (srst_n && vif.ast_valid_o && vif.ast_ready_i) begin
      obs_q.push_back(word_t'({vif.ast_data_o, vif.ast_startofpacket_o, vif.ast_endofpacket_o,
                               vif.ast_empty_o, vif.ast_channel_o}));
      obs_cyc.push_back(cyc);
    end
    if (srst_n && vif.ast_valid_i && vif.ast_ready_o) acc_cyc.push_back(cyc);
  end

  task automatic add_beat(input logic [DATA_IN_W-1:0] d, input bit s, input bit e,
                          input int emp, input int ch);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e;
    b.empty = EMPTY_IN_W'(emp); b.ch = CHANNEL_W'(ch);
    beat_q.push_back(b);
  endtask

  // Reference: valid bytes of each beat cut into WB-byte words in order.
  task automatic build_expect();
    int nb, nw;
    word_t w;
    exp_q.delete();
    foreach (beat_q[i]) begin
      nb = beat_q[i].eop ? IB - int'(beat_q[i].empty) : IB;
      nw = (nb + WB - 1) / WB;
      for (int k = 0; k < nw; k++) begin
        w.d   = DATA_OUT_W'(beat_q[i].data >> (k * DATA_OUT_W));
        w.sop = beat_q[i].sop && (k == 0);
        w.eop = beat_q[i].eop && (k == nw - 1);
        w.emp = w.eop ? EMPTY_OUT_W'(nw * WB - nb) : EMPTY_OUT_W'(0);
        w.ch  = beat_q[i].ch;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic drive_src(input int gap_max);
    bit acc;
    int to;
    for (int i = 0; i < beat_q.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          vif.ast_valid_i = 1'b0; @(posedge clk); #1;
        end
      end
      vif.ast_data_i = beat_q[i].data;
      vif.ast_startofpacket_i = beat_q[i].sop;
      vif.ast_endofpacket_i = beat_q[i].eop;
      vif.ast_empty_i = beat_q[i].empty;
      vif.ast_channel_i = beat_q[i].ch;
      vif.ast_valid_i = 1'b1;
      acc = 1'b0; to = 0;
      while (!acc && to < 500) begin
        @(negedge clk); acc = vif.ast_ready_o;
        @(posedge clk); #1; to++;
      end
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL src_timeout: beat %0d not accepted, ready_o=%b want 1", i, vif.ast_ready_o);
      end
    end
    vif.ast_valid_i = 1'b0;
    vif.ast_data_i = {$urandom, $urandom};
    src_done = 1'b1;
  endtask

  task automatic drive_sink(input int mode, input int budget);
    int c = 0;
    while (!(src_done && obs_q.size() >= exp_q.size()) && c < budget) begin
      vif.ast_ready_i = (mode == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
      @(posedge clk); #1; c++;
    end
    vif.ast_ready_i = 1'b1;
    if (c >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic run_stream(input int gap_max, input int mode);
    build_expect();
    clear_obs();
    src_done = 1'b0;
    fork
      drive_src(gap_max);
      drive_sink(mode, 3000);
    join
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_tests++;
    if ({vif.ast_ready_o, vif.ast_valid_o, vif.ast_startofpacket_o, vif.ast_endofpacket_o,
         vif.ast_data_o, vif.ast_empty_o, vif.ast_channel_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b sop=%b eop=%b data=%h emp=%h ch=%h want all 0",
               vif.ast_ready_o, vif.ast_valid_o, vif.ast_startofpacket_o, vif.ast_endofpacket_o,
               vif.ast_data_o, vif.ast_empty_o, vif.ast_channel_o);
    end
    @(posedge clk); #1; srst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (vif.ast_ready_o !== 1'b1 || vif.ast_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready_o=%b valid_o=%b want 1/0", vif.ast_ready_o, vif.ast_valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_beat();
    word_t w;
    beat_q.delete();
    add_beat(64'h0807060504030201, 1'b1, 1'b1, 0, 3);
    run_stream(0, 0);
    n_tests++;
    if (obs_q.size() != 4 || exp_q.size() != 4) begin
      n_fail++; $display("FAIL full_count: got %0d words want 4", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) if (i < obs_q.size()) begin
      w = obs_q[i];
      n_tests++;
      if (w.d !== 16'(16'h0201 + i * 16'h0202) || w.sop !== (i == 0) || w.eop !== (i == 3)) begin
        n_fail++; $display("FAIL full_const%0d: got d=%h sop=%b eop=%b", i, w.d, w.sop, w.eop);
      end
    end
    if (obs_cyc.size() == 4) begin
      n_tests++;
      if (obs_cyc[3] - obs_cyc[0] != 3) begin
        n_fail++; $display("FAIL full_contig: span %0d want 3", obs_cyc[3] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_partial_eop();
    word_t w;
    beat_q.delete();
    add_beat(64'h0807060504030201, 1'b1, 1'b1, 3, 7);
    run_stream(0, 0);
    n_tests++;
    if (obs_q.size() != 3) begin
      n_fail++; $display("FAIL partial_count: got %0d words want 3", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL partial_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 0) begin
      w = obs_q[obs_q.size() - 1];
      n_tests++;
      if (w.d[7:0] !== 8'h05 || w.eop !== 1'b1 || w.emp !== 1'b1) begin
        n_fail++; $display("FAIL partial_last: got byte=%h eop=%b emp=%h want 05/1/1", w.d[7:0], w.eop, w.emp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nsop, neop, span;
    word_t w;
    beat_q.delete();
    for (int i = 0; i < 3; i++) add_beat({$urandom, $urandom}, i == 0, i == 2, 0, 5);
    run_stream(0, 0);
    n_tests++;
    if (obs_q.size() != 12) begin
      n_fail++; $display("FAIL b2b_count: got %0d words want 12", obs_q.size());
    end
    nsop = 0; neop = 0;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      w = obs_q[i]; nsop += w.sop; neop += w.eop;
      n_tests++;
      if (obs_q[i] !== exp_q[i] || w.ch !== 10'd5) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (nsop != 1 || neop != 1) begin
      n_fail++; $display("FAIL b2b_framing: got sop=%0d eop=%0d want 1/1", nsop, neop);
    end
    if (obs_cyc.size() == 12) begin
      span = obs_cyc[11] - obs_cyc[0];
      n_tests++;
      if (span != (REG_RDY ? 13 : 11)) begin
        n_fail++; $display("FAIL b2b_span: got %0d want %0d", span, REG_RDY ? 13 : 11);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_q.delete();
    add_beat({$urandom, $urandom}, 1'b1, 1'b1, 0, $urandom_range(1023, 0));
    build_expect();
    clear_obs();
    vif.ast_ready_i = 1'b1;
    vif.ast_data_i = beat_q[0].data; vif.ast_startofpacket_i = 1'b1; vif.ast_endofpacket_i = 1'b1;
    vif.ast_empty_i = '0; vif.ast_channel_i = beat_q[0].ch; vif.ast_valid_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (vif.ast_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept: ready_o=%b want 1", vif.ast_ready_o);
    end
    @(posedge clk); #1; vif.ast_valid_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 3; k++) begin
      vif.ast_ready_i = (k == 2);
      @(negedge clk);
      n_tests++;
      if (vif.ast_data_o !== exp_q[2].d || vif.ast_valid_o !== 1'b1 || vif.ast_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: data=%h vld=%b rdy=%b want %h/1/0",
                           k, vif.ast_data_o, vif.ast_valid_o, vif.ast_ready_o, exp_q[2].d);
      end
      @(posedge clk); #1;
    end
    vif.ast_ready_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (vif.ast_ready_o !== 1'b0 || vif.ast_endofpacket_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_last_hold: rdy=%b eop=%b want 0/1", vif.ast_ready_o, vif.ast_endofpacket_o);
    end
    @(posedge clk); #1; vif.ast_ready_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (vif.ast_ready_o !== !REG_RDY) begin
      n_fail++; $display("FAIL bp_last_ready: rdy=%b want %b", vif.ast_ready_o, !REG_RDY);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_tests++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d words want 4", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    vif.ast_ready_i = 1'b1;
    vif.ast_data_i = {$urandom, $urandom}; vif.ast_startofpacket_i = 1'b1; vif.ast_endofpacket_i = 1'b0;
    vif.ast_empty_i = '0; vif.ast_channel_i = 10'd9; vif.ast_valid_i = 1'b1;
    @(posedge clk); #1; vif.ast_valid_i = 1'b0;
    @(posedge clk); #1;
    vif.ast_ready_i = 1'b0; srst_n = 1'b0;
    @(posedge clk); #1; srst_n = 1'b1; vif.ast_ready_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (vif.ast_valid_o !== 1'b0 || vif.ast_ready_o !== 1'b0 || obs_q.size() != 1) begin
      n_fail++; $display("FAIL rstmid_flush: vld=%b rdy=%b words=%0d want 0/0/1",
                         vif.ast_valid_o, vif.ast_ready_o, obs_q.size());
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (vif.ast_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_ready: rdy=%b want 1", vif.ast_ready_o);
    end
    @(posedge clk); #1;
    beat_q.delete();
    add_beat({$urandom, $urandom}, 1'b1, 1'b1, $urandom_range(IB - 1, 0), 11);
    run_stream(0, 0);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_byte_eop();
    word_t w;
    beat_q.delete();
    add_beat({$urandom, $urandom}, 1'b1, 1'b0, 5, 2);
    add_beat({$urandom, $urandom}, 1'b0, 1'b1, 7, 2);
    add_beat({$urandom, $urandom}, 1'b1, 1'b1, 0, 4);
    run_stream(0, 0);
    n_tests++;
    if (obs_q.size() != 9) begin
      n_fail++; $display("FAIL onebyte_count: got %0d words want 9", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL onebyte_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 4 && acc_cyc.size() == 3) begin
      w = obs_q[4];
      n_tests++;
      if (w.sop !== 1'b0 || w.eop !== 1'b1 || w.emp !== 1'b1) begin
        n_fail++; $display("FAIL onebyte_flags: sop=%b eop=%b emp=%h want 0/1/1", w.sop, w.eop, w.emp);
      end
      n_tests++;
      if (acc_cyc[2] - obs_cyc[4] != (REG_RDY ? 1 : 0)) begin
        n_fail++; $display("FAIL onebyte_overlap: accept-transfer gap %0d want %0d",
                           acc_cyc[2] - obs_cyc[4], REG_RDY ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    int len, ch;
    beat_q.delete();
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(4, 1);
      ch = $urandom_range(1023, 0);
      for (int j = 0; j < len; j++)
        add_beat({$urandom, $urandom}, j == 0, j == len - 1, $urandom_range(IB - 1, 0), ch);
    end
    run_stream(3, 1);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    vif.ast_valid_i = 1'b0;
    vif.ast_ready_i = 1'b1;
    vif.ast_data_i = '0;
    vif.ast_startofpacket_i = 1'b0;
    vif.ast_endofpacket_i = 1'b0;
    vif.ast_empty_i = '0;
    vif.ast_channel_i = '0;
    test_reset();
    test_full_beat();
    test_partial_eop();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_single_byte_eop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ast_width_reducer.md
Name: ast_width_reducer

Overview:
Avalon-ST width down-converter. It takes wide packets (for example the output of the team's width extender, or any wide AST stage) and re-emits them as a stream of narrower words. Channel, start-of-packet, end-of-packet and empty are preserved and recomputed for the narrow side. It sits directly downstream of the wide datapath, feeding narrow consumers and loop-back checks that close extender→reducer paths.

Parameters:
DATA_IN_W, 64, wide input data width in bits; must be a multiple of DATA_OUT_W
EMPTY_IN_W, $clog2(DATA_IN_W/8), input empty width
DATA_OUT_W, 16, narrow output data width in bits; must be a multiple of 8
EMPTY_OUT_W, $clog2(DATA_OUT_W/8) (min 1), output empty width
CHANNEL_W, 10, channel width

Ports:
clk_i  in  1  clock
srst_n_i  in  1  synchronous active-low reset
ast_data_i  in  DATA_IN_W  wide data; first byte in bits [7:0]
ast_startofpacket_i  in  1  first beat of packet
ast_endofpacket_i  in  1  last beat of packet
ast_valid_i  in  1  input beat valid
ast_empty_i  in  EMPTY_IN_W  unused bytes in eop beat (top bytes)
ast_channel_i  in  CHANNEL_W  channel
ast_ready_o  out  1  reducer can accept a beat
ast_data_o  out  DATA_OUT_W  narrow data; first byte in bits [7:0]
ast_startofpacket_o  out  1  first word of packet
ast_endofpacket_o  out  1  last word of packet
ast_valid_o  out  1  output word valid
ast_empty_o  out  EMPTY_OUT_W  unused top bytes in eop word
ast_channel_o  out  CHANNEL_W  channel of current word
ast_ready_i  in  1  downstream accepts word

Behaviour:
- Clock is clk_i. Reset srst_n_i is synchronous and active-low; it is sampled on the clk_i rising edge.
- Derived constants: N = DATA_IN_W/DATA_OUT_W, WB = DATA_OUT_W/8, IB = DATA_IN_W/8.
- Input handshake: a beat transfers when ast_valid_i && ast_ready_o. Output handshake: a word transfers when ast_valid_o && ast_ready_i.
- FSM has two states:
  - IDLE: buffer empty; ast_ready_o=1, ast_valid_o=0.
  - SEND: holds one beat plus word index idx (0..last_idx); ast_valid_o=1.
- Capture: an accepted beat registers data, sop, eop, empty and channel. idx:=0. Next state is SEND. The first word appears the cycle after acceptance (latency 1).
- Word count:
  - Non-eop beat: last_idx = N-1, and ast_empty_i is ignored.
  - Eop beat: vb = IB - empty_i and last_idx = ceil(vb/WB) - 1. Words beyond last_idx are never emitted.
- Outputs in SEND:
  - data_o = held data[idx*DATA_OUT_W +: DATA_OUT_W].
  - sop_o = held_sop && idx==0.
  - eop_o = held_eop && idx==last_idx.
  - empty_o = (last_idx+1)*WB - vb when eop_o, else 0.
  - channel_o = held channel on every word.
- Advance: on an output transfer with idx<last_idx, idx++. On an output transfer with idx==last_idx, either capture a new beat (if an input transfer happens in the same cycle) or go to IDLE.
- Ready (default build): ast_ready_o = (state==IDLE) || (idx==last_idx && ast_ready_i). This is a combinational ready_i→ready_o path. It gives full throughput: a full beat costs N cycles with no bubbles.
- Backpressure: while ast_ready_i=0, all outputs hold stable. Valid never drops before the word transfers.
- Reset values (also while srst_n_i=0): ast_ready_o=0, ast_valid_o=0, sop/eop=0, data/empty/channel=0, state=IDLE, idx=0. ast_ready_o rises the first cycle after reset is released.
- Reset mid-packet discards the held beat. No eop is synthesized. The next sop starts clean.
- Packet framing is passed through; the block does not check it. A single beat with sop&&eop produces a packet that is sop on word 0 and eop on word last_idx. This can be one word carrying both sop and eop.
- Input sop/eop/valid are ignored while ast_ready_o=0.

Optional Feature:
AST_WIDTH_REDUCER_REG_READY_EN
- Defined: ast_ready_o = (state==IDLE), registered, with no combinational dependence on ast_ready_i. There is one bubble cycle per input beat, so a full beat costs N+1 cycles. Output word order and values are identical.
- Undefined: ready behaviour as described under Behaviour.

Decomposition:
- usr_types_and_params holds DATA_IN_W, DATA_OUT_W, EMPTY_IN_W, EMPTY_OUT_W, CHANNEL_W, N and WB.
- The same package holds the state enum typedef (IDLE, SEND) and a function words_in_beat(eop, empty) returning last_idx.
- No sub-module: the word mux and counter live inline.
- The bench reuses ast_interface, extended with a second narrow port set.

Test Plan:
- Single beat, sop=eop=1, data=64'h0807060504030201, empty_i=0 → 4 words 0x0201, 0x0403, 0x0605, 0x0807; sop on word 0, eop on word 3, empty_o=0, 4 consecutive cycles.
- Single beat, sop=eop=1, empty_i=3 (5 bytes) → 3 words; last word data[7:0]=0x05, eop=1, empty_o=1.
- 3-beat packet on channel 5, ready_i=1, valid_i held high → 12 contiguous words with no bubbles, all channel_o=5, one sop and one eop. Under REG_READY_EN: 15 cycles, with a bubble after every 4th word.
- ready_i toggling 1,0,0,1 during word 2 → word 2 held stable for 3 cycles; ast_ready_o=0 throughout; no word lost or duplicated.
- srst_n_i pulled low for 1 cycle during word 1 of a 4-word beat → valid_o=0 in the next cycle; a new sop beat afterwards emits cleanly from word 0.
- Eop beat with empty_i=7 (1 byte) → single word with sop=0, eop=1, empty_o=1; the next beat is accepted in the same cycle as that word's transfer.
